// File: rtl/burst_arb_pkg.sv
// Shared types and defaults for the burst-grant arbiter.
// Optional checkers: BURST_ARB_SVA_EN.
package burst_arb_pkg;

  localparam int BURST_ARB_NUM_CH_DEF = 4;
  localparam int BURST_ARB_CNT_W_DEF  = 3;

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_e;

endpackage

// File: rtl/burst_grant_arb_rr_picker.sv
// Combinational round-robin picker: first set
// request at or after ptr, wrapping modulo NUM_CH.
module rr_picker #(
  parameter  int NUM_CH = 4,
  localparam int IW     = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IW-1:0]     ptr,
  output logic [NUM_CH-1:0] win,
  output logic [IW-1:0]     idx,
  output logic              valid
);

  logic [IW-1:0] c;

  always_comb begin
    win   = '0;
    idx   = '0;
    valid = 1'b0;
    c     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      c = IW'((int'(ptr) + i) % NUM_CH);
      if (!valid && req[c]) begin
        valid  = 1'b1;
        idx    = c;
        win[c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/burst_grant_arb.sv
// Round-robin burst-grant arbiter, registered outputs.
// Optional checkers: BURST_ARB_SVA_EN.
module burst_grant_arb
  import burst_arb_pkg::*;
#(
  parameter  int NUM_CH = BURST_ARB_NUM_CH_DEF,
  parameter  int CNT_W  = BURST_ARB_CNT_W_DEF,
  localparam int IW     = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       req,
  input  logic [NUM_CH*CNT_W-1:0] num_grants,
  output logic [NUM_CH-1:0]       gnt,
  output logic [IW-1:0]           gnt_idx,
  output logic                    last,
  output logic                    busy
);

  arb_state_e        state, state_n;
  logic [CNT_W-1:0]  remaining, rem_n;
  logic [IW-1:0]     rr_ptr, ptr_n;
  logic [NUM_CH-1:0] mask, mask_n;
  logic [NUM_CH-1:0] gnt_n;
  logic [IW-1:0]     idx_n;
  logic              last_n, busy_n;

  logic [NUM_CH-1:0] pick_win;
  logic [IW-1:0]     pick_idx;
  logic              pick_valid;
  logic [CNT_W-1:0]  len_arr [NUM_CH];
  logic [CNT_W-1:0]  len;

  rr_picker #(.NUM_CH(NUM_CH)) u_pick (
    .req   (req & ~mask),
    .ptr   (rr_ptr),
    .win   (pick_win),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_comb begin
    for (int c = 0; c < NUM_CH; c++)
      len_arr[c] = num_grants[c*CNT_W +: CNT_W];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ARB_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    len = len_arr[pick_idx];
    if (len == '0) len = CNT_W'(1);
    state_n = state;
    rem_n   = remaining;
    ptr_n   = rr_ptr;
    mask_n  = '0;
    gnt_n   = '0;
    idx_n   = gnt_idx;
    last_n  = 1'b0;
    busy_n  = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        if (pick_valid) begin
          state_n = ARB_GRANT;
          rem_n   = len;
          gnt_n   = pick_win;
          idx_n   = pick_idx;
          busy_n  = 1'b1;
          last_n  = (len == CNT_W'(1));
        end
      end
      ARB_GRANT: begin
        // dropped request aborts exactly like a completion
        if (!req[gnt_idx] || remaining == CNT_W'(1)) begin
          state_n = ARB_IDLE;
          rem_n   = '0;
          mask_n  = gnt;
          ptr_n   = (gnt_idx == IW'(NUM_CH-1)) ?
                    '0 : gnt_idx + 1'b1;
        end else begin
          rem_n  = remaining - 1'b1;
          gnt_n  = gnt;
          busy_n = 1'b1;
          last_n = (remaining == CNT_W'(2));
        end
      end
      default: state_n = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      remaining <= '0;
      rr_ptr    <= '0;
      mask      <= '0;
      gnt       <= '0;
      gnt_idx   <= '0;
      last      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      remaining <= rem_n;
      rr_ptr    <= ptr_n;
      mask      <= mask_n;
      gnt       <= gnt_n;
      gnt_idx   <= idx_n;
      last      <= last_n;
      busy      <= busy_n;
    end
  end

`ifdef BURST_ARB_SVA_EN
  a_onehot: assert property (@(posedge clk)
    disable iff (reset) $onehot0(gnt));

  a_last_busy: assert property (@(posedge clk)
    disable iff (reset) last |-> busy);

  a_idx: assert property (@(posedge clk)
    disable iff (reset)
    busy |-> (gnt[gnt_idx] && $onehot(gnt)));

  a_idle: assert property (@(posedge clk)
    disable iff (reset) !busy |-> (gnt == '0));

  a_len: assert property (@(posedge clk)
    disable iff (reset)
    busy |-> (last == (remaining == CNT_W'(1))));

  a_hold: assert property (@(posedge clk)
    disable iff (reset)
    (busy && !last && req[gnt_idx]) |=>
    (busy && gnt == $past(gnt)));

  a_end: assert property (@(posedge clk)
    disable iff (reset) last |=> !busy);

  a_req: assert property (@(posedge clk)
    disable iff (reset) (gnt & ~$past(req)) == '0);

  c_b2b: cover property (@(posedge clk)
    disable iff (reset)
    last ##1 !busy ##1
    (busy && gnt_idx != $past(gnt_idx, 2)));
`else
  // checkers compiled out
`endif

endmodule

// File: tb/tb_burst_grant_arb.sv
// Scoreboard bench for burst_grant_arb: directed
// bursts, abort, mask, round-robin and async reset.
module tb_burst_grant_arb;

  typedef struct packed {
    int         cyc;
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       last;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [11:0] num_grants;
  logic [3:0]  gnt;
  logic [1:0]  gnt_idx;
  logic        last;
  logic        busy;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  burst_grant_arb #(.NUM_CH(4), .CNT_W(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .num_grants (num_grants),
    .gnt        (gnt),
    .gnt_idx    (gnt_idx),
    .last       (last),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not end");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic at_cycle(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  task automatic push_burst(input int start,
                            input int ch,
                            input int n,
                            input bit ends);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.cyc  = start + i;
      e.gnt  = 4'(1 << ch);
      e.idx  = 2'(ch);
      e.last = ends && (i == n - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic set_len(input int ch, input int n);
    num_grants[ch*3 +: 3] = 3'(n);
  endtask

  // monitor: pops one expectation per grant cycle
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        n_checks++;
        if (!busy || gnt !== e.gnt ||
            gnt_idx !== e.idx || last !== e.last) begin
          n_fail++;
          $display("FAIL grant@%0d: got busy=%b gnt=%b idx=%0d last=%b, expected gnt=%b idx=%0d last=%b",
                   cyc, busy, gnt, gnt_idx, last,
                   e.gnt, e.idx, e.last);
        end
      end else if (busy) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_grant@%0d: got gnt=%b last=%b, expected none",
                 cyc, gnt, last);
      end
    end
  end

  initial begin
    reset      = 1'b1;
    req        = '0;
    num_grants = '0;

    at_cycle(1);
    #1;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_idx", 32'(gnt_idx), 0);
    chk("rst_last", 32'(last), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ptr", 32'(dut.rr_ptr), 0);
    at_cycle(2);
    #2 reset = 1'b0;

    // ch0 only, length 2, request rises at cycle 5
    set_len(0, 2);
    at_cycle(5);
    req[0] = 1'b1;
    push_burst(6, 0, 2, 1);
    at_cycle(8);
    req[0] = 1'b0;

    // abort: ch1 len 5 drops after 2 grants; ch3 waits
    at_cycle(12);
    set_len(1, 5);
    set_len(3, 1);
    req = 4'b1010;
    push_burst(13, 1, 2, 0);
    push_burst(16, 3, 1, 1);
    at_cycle(14);
    req[1] = 1'b0;
    at_cycle(17);
    req[3] = 1'b0;
    at_cycle(18);
    chk("ptr_after_abort", 32'(dut.rr_ptr), 0);

    // simultaneous ch0 (len 3) and ch2 (len 2)
    at_cycle(20);
    set_len(0, 3);
    set_len(2, 2);
    req = 4'b0101;
    push_burst(21, 0, 3, 1);
    push_burst(25, 2, 2, 1);
    at_cycle(24);
    req[0] = 1'b0;
    at_cycle(27);
    req[2] = 1'b0;
    at_cycle(28);
    chk("ptr_after_pair", 32'(dut.rr_ptr), 3);

    // ch1 length field 0 behaves as 1
    at_cycle(32);
    set_len(1, 0);
    req[1] = 1'b1;
    push_burst(33, 1, 1, 1);
    at_cycle(34);
    req[1] = 1'b0;
    at_cycle(35);
    chk("ptr_after_zero", 32'(dut.rr_ptr), 2);

    // ch2 holds req past last: one masked cycle
    at_cycle(40);
    set_len(2, 2);
    set_len(0, 1);
    req[2] = 1'b1;
    push_burst(41, 2, 2, 1);
    push_burst(45, 2, 2, 1);
    push_burst(48, 0, 1, 1);
    push_burst(50, 2, 2, 1);
    at_cycle(47);
    req[0] = 1'b1;
    at_cycle(49);
    req[0] = 1'b0;
    at_cycle(52);
    req[2] = 1'b0;
    at_cycle(53);
    chk("ptr_after_mask", 32'(dut.rr_ptr), 3);

    // async reset during 2nd of 4 grants
    at_cycle(60);
    set_len(0, 4);
    set_len(1, 1);
    req = 4'b0011;
    push_burst(61, 0, 2, 0);
    at_cycle(62);
    #2 reset = 1'b1;
    #1;
    chk("midrst_gnt", 32'(gnt), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_last", 32'(last), 0);
    chk("midrst_idx", 32'(gnt_idx), 0);
    chk("midrst_ptr", 32'(dut.rr_ptr), 0);
    chk("midrst_rem", 32'(dut.remaining), 0);
    at_cycle(64);
    push_burst(65, 0, 4, 1);
    push_burst(70, 1, 1, 1);
    #2 reset = 1'b0;
    at_cycle(69);
    req[0] = 1'b0;
    at_cycle(71);
    req[1] = 1'b0;
    at_cycle(72);
    chk("ptr_after_rst", 32'(dut.rr_ptr), 2);

    at_cycle(76);
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
